// File: rtl/mul_iter.sv
// Iterative N x N multiplier, signed or unsigned per operation, retiring R multiplier bits per cycle.
// Latency: ITER = ceil(N/R) cycles from the accepting edge to out_valid; minimum initiation interval ITER+2.
// Backpressure: one operation in flight; in_ready only in IDLE, and the result is held in DONE until out_ready.
module mul_iter #(
    parameter int N = 23,
    parameter int R = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] z,
    output logic           busy
);

    localparam int ITER = (N + R - 1) / R;
    localparam int MW   = ITER * R;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;    // |x|, pre-shifted to the weight of the current digit
    logic [MW-1:0]  mplier;   // |y|, shifted right so the current digit sits at the bottom
    logic [CW-1:0]  cnt;
    logic           neg;

    logic [N-1:0]   x_mag;
    logic [N-1:0]   y_mag;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc_sum;
    logic           accept;
    logic           last;

    // Operand magnitudes and the partial-product sum for this iteration.
    // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude 2^(N-1).
    always_comb begin
        x_mag   = (sgn && x[N-1]) ? -x : x;
        y_mag   = (sgn && y[N-1]) ? -y : y;
        accept  = in_valid && (state == IDLE);
        last    = (cnt == LAST);
        pp      = mcand * (2*N)'(mplier[R-1:0]);
        acc_sum = acc + pp;
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture magnitudes on accept, accumulate one digit per CALC cycle,
    // and apply the sign to the final sum as it is loaded into z.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            z      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= (2*N)'(x_mag);
                        mplier <= MW'(y_mag);
                        neg    <= sgn & (x[N-1] ^ y[N-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << R;
                    mplier <= mplier >> R;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        z <= neg ? -acc_sum : acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative multiplier, the next generation of the synchronous mantissa multiplier `mul`. It adds a valid/ready handshake on both sides, a configurable radix (R multiplier bits retired per cycle), and a per-operation signed/unsigned mode. It sits in the FP multiply datapath as the N×N mantissa product unit and trades latency for area relative to the cascade version.

## Interface
- N, 23, operand width in bits; N >= 2
- R, 1, multiplier bits consumed per iteration; 1 <= R <= N
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present on x, y, sgn
- in_ready  out  1  block can accept operands
- x  in  N  multiplicand
- y  in  N  multiplier
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with x, y
- out_valid  out  1  z holds a completed product
- out_ready  in  1  consumer takes z
- z  out  2N  product, two's complement when the captured sgn = 1
- busy  out  1  operation in flight (CALC or DONE)

## Operation
- ITER = ceil(N/R). The multiplier magnitude is zero-extended to ITER*R bits.
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture:
    - |x| and |y|, where magnitude is taken only if sgn = 1 and the MSB = 1;
    - neg = sgn & (x[N-1] ^ y[N-1]);
    - acc = 0 and cnt = 0.
  - Go to CALC.
- CALC:
  - Each cycle: acc += |x| * (next R-bit digit of |y|, LSB first) << (cnt*R), then cnt++.
  - acc is 2N bits wide and never overflows.
  - When cnt reaches ITER-1 in this cycle, load z = neg ? -acc_final : acc_final, set out_valid = 1, and go to DONE.
- DONE:
  - z and out_valid are held stable until out_ready = 1.
  - On out_valid & out_ready: out_valid = 0, go to IDLE.
  - z keeps its last value after the handshake.
- in_ready = 1 only in IDLE. in_valid outside IDLE is ignored, and operands are not queued.
- busy = (state != IDLE).
- Signed corner case: -2^(N-1) × -2^(N-1) = +2^(2N-2), which is representable. Magnitudes fit in N bits unsigned.
- x, y and sgn may change freely after the accepting edge. Captured copies are used.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, z = 0, busy = 0;
  - acc, cnt and neg are all 0.
- No handshake completes while rst = 0.
- Reset asserted mid-operation (CALC or DONE) immediately aborts:
  - out_valid drops to 0 and z clears to 0 asynchronously;
  - the operation is lost.
- Latency: the operand-accept edge is edge 0. out_valid is first high after edge ITER, i.e. ITER cycles after acceptance.
  - N=23, R=1: 23 cycles.
  - N=23, R=4: 6 cycles.
  - N=23, R=23: 1 cycle.
- Minimum initiation interval is ITER+2 cycles: ITER in CALC, at least 1 in DONE, 1 in IDLE.
- Back-pressure: if out_ready = 0, DONE persists indefinitely with z constant.
- If out_ready = 1 on the first DONE cycle, the result transfers in that cycle and IDLE follows on the next edge.
- in_valid and out_ready are both high in DONE: only the output transfer occurs. in_ready = 0, so the input must be re-presented in IDLE.

## Test plan
- Reset/idle:
  - Stimulus: hold rst = 0 for 3 cycles with in_valid = 1 and random x, y, then release.
  - Required: out_valid = 0, z = 0, busy = 0, in_ready = 1 throughout; no operation starts before release.
- Unsigned, N=23, R=1:
  - Stimulus: x = 0x7FFFFF, y = 0x7FFFFF, sgn = 0.
  - Required: out_valid rises exactly 23 cycles after acceptance, z = 0x3FFFFF000001.
- Signed corners, N=23, R=4:
  - Stimulus: three operations with sgn = 1:
    - x = 0x7FFFFF (-1), y = 0x000002;
    - x = y = 0x400000 (-2^22);
    - x = 0, y = 0x400000.
  - Required:
    - z = 0x3FFFFFFFFFFE (-2) after 6 cycles;
    - z = 0x100000000000;
    - z = 0.
- Back-pressure:
  - Stimulus: out_ready = 0 for 10 cycles after out_valid rises, with in_valid = 1 and new x, y toggling.
  - Required: z stable, in_ready = 0, busy = 1; the transfer completes on the first out_ready = 1 cycle; the next operand pair is accepted in IDLE.
- Reset mid-CALC:
  - Stimulus: accept an operation, assert rst after 5 cycles, release, then issue x = 3, y = 5, sgn = 0.
  - Required: no out_valid for the aborted operation; the second result is z = 15.
- Random regression:
  - Stimulus: 1000 randomized x, y, sgn and random out_ready stalls, for R ∈ {1, 3, 23}.
  - Required: every z matches the reference model `(sgn ? $signed : unsigned) x*y` truncated to 2N bits, and latency equals ITER for each R.
